// File: rtl/ase_pkg.sv
// Shared CCI-P TX definitions and tid scheduler types.
// The TX meta type field location is exported as `TX_META_TYPERANGE.
`ifndef TX_META_TYPERANGE
`define TX_META_TYPERANGE 3:0
`endif

package ase_pkg;

  localparam int CCIP_TX_HDR_WIDTH = 74;

  localparam logic [3:0] CCIP_WRFENCE = 4'h4;

  typedef enum logic {
    TS_INIT,
    TS_RUN
  } tid_sched_state_e;

  // Reference value of the tid carried by a write fence (all-ones).
  localparam logic [31:0] TID_FENCE_MARK = 32'hFFFF_FFFF;

endpackage

// File: rtl/ase_tid_free_fifo.sv
// Free-tid FIFO: NUM_TID entries of $clog2(NUM_TID) bits, head shown combinationally.
// Same-cycle push and pop are supported; the caller never pops when empty or pushes when full.
module ase_tid_free_fifo #(
  parameter int NUM_TID = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [$clog2(NUM_TID)-1:0] push_data,
  input  logic                       pop,
  output logic [$clog2(NUM_TID)-1:0] pop_data,
  output logic [$clog2(NUM_TID):0]   count
);

  localparam int LW = $clog2(NUM_TID);

  logic [LW-1:0] mem_q [NUM_TID];
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + LW'(push);
    rd_ptr_d = rd_ptr_q + LW'(pop);
    count_d  = count_q + (LW+1)'(push) - (LW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/ase_tid_scheduler.sv
// Tags CCI-P TX requests with recyclable tids, bounds outstanding work and drains before fences.
// Optional statistics ports (max_outstanding, stall_cycles) exist only with ASE_TID_SCHED_STATS_EN.
module ase_tid_scheduler
  import ase_pkg::*;
#(
  parameter int HDR_WIDTH = CCIP_TX_HDR_WIDTH,
  parameter int TID_WIDTH = 32,
  parameter int NUM_TID   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic [HDR_WIDTH-1:0]       req_meta,
  output logic                       req_ready,
  output logic                       out_valid,
  output logic [HDR_WIDTH-1:0]       out_meta,
  output logic [TID_WIDTH-1:0]       out_tid,
  input  logic                       out_ready,
  input  logic                       cpl_valid,
  input  logic [TID_WIDTH-1:0]       cpl_tid,
  output logic [$clog2(NUM_TID):0]   outstanding,
  output logic                       err_bad_cpl
`ifdef ASE_TID_SCHED_STATS_EN
  ,
  output logic [$clog2(NUM_TID):0]   max_outstanding,
  output logic [31:0]                stall_cycles
`endif
);

  localparam int LW = $clog2(NUM_TID);
  localparam int OW = LW + 1;

  tid_sched_state_e     state_q, state_d;
  logic [LW-1:0]        init_cnt_q, init_cnt_d;
  logic [NUM_TID-1:0]   bitmap_q, bitmap_d;
  logic                 out_valid_q, out_valid_d;
  logic [HDR_WIDTH-1:0] out_meta_q, out_meta_d;
  logic [TID_WIDTH-1:0] out_tid_q, out_tid_d;
  logic [OW-1:0]        outstanding_q, outstanding_d;
  logic                 err_bad_cpl_q, err_bad_cpl_d;

  logic                 is_fence;
  logic                 running;
  logic                 stage_free;
  logic                 accept;
  logic                 alloc;
  logic [LW-1:0]        cpl_idx;
  logic                 cpl_hit;
  logic                 fifo_push;
  logic [LW-1:0]        fifo_push_data;
  logic [LW-1:0]        fifo_head;
  logic [OW-1:0]        free_count;

  ase_tid_free_fifo #(
    .NUM_TID(NUM_TID)
  ) u_free_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(fifo_push_data),
    .pop      (alloc),
    .pop_data (fifo_head),
    .count    (free_count)
  );

  // No bypass: a completion only frees its tid for the following cycle.
  always_comb begin
    is_fence   = (req_meta[`TX_META_TYPERANGE] == CCIP_WRFENCE);
    running    = (state_q == TS_RUN);
    stage_free = !out_valid_q || out_ready;
    req_ready  = !rst && running && stage_free &&
                 (is_fence ? (outstanding_q == '0) : (free_count != '0));
    accept     = req_valid && req_ready;
    alloc      = accept && !is_fence;
    cpl_idx    = cpl_tid[LW-1:0];
    cpl_hit    = cpl_valid && running && ((cpl_tid >> LW) == '0) && bitmap_q[cpl_idx];
  end

  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    bitmap_d       = bitmap_q;
    out_valid_d    = out_valid_q;
    out_meta_d     = out_meta_q;
    out_tid_d      = out_tid_q;
    outstanding_d  = outstanding_q + OW'(alloc) - OW'(cpl_hit);
    err_bad_cpl_d  = cpl_valid && !cpl_hit;
    fifo_push      = cpl_hit;
    fifo_push_data = cpl_idx;

    if (!running) begin
      fifo_push      = 1'b1;
      fifo_push_data = init_cnt_q;
      init_cnt_d     = init_cnt_q + 1'b1;
      if (init_cnt_q == LW'(NUM_TID - 1)) begin
        state_d = TS_RUN;
      end
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_meta_d  = req_meta;
      out_tid_d   = is_fence ? '1 : TID_WIDTH'(fifo_head);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // The allocated and retired tids always differ: the retired bit is already set.
    if (alloc) begin
      bitmap_d[fifo_head] = 1'b1;
    end
    if (cpl_hit) begin
      bitmap_d[cpl_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= TS_INIT;
      init_cnt_q    <= '0;
      bitmap_q      <= '0;
      out_valid_q   <= 1'b0;
      out_meta_q    <= '0;
      out_tid_q     <= '0;
      outstanding_q <= '0;
      err_bad_cpl_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      bitmap_q      <= bitmap_d;
      out_valid_q   <= out_valid_d;
      out_meta_q    <= out_meta_d;
      out_tid_q     <= out_tid_d;
      outstanding_q <= outstanding_d;
      err_bad_cpl_q <= err_bad_cpl_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_meta    = out_meta_q;
  assign out_tid     = out_tid_q;
  assign outstanding = outstanding_q;
  assign err_bad_cpl = err_bad_cpl_q;

`ifdef ASE_TID_SCHED_STATS_EN
  logic [OW-1:0] max_outstanding_q, max_outstanding_d;
  logic [31:0]   stall_cycles_q, stall_cycles_d;

  always_comb begin
    max_outstanding_d = (outstanding_d > max_outstanding_q) ? outstanding_d : max_outstanding_q;
    stall_cycles_d    = stall_cycles_q;
    if (running && req_valid && !req_ready && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_outstanding_q <= '0;
      stall_cycles_q    <= '0;
    end else begin
      max_outstanding_q <= max_outstanding_d;
      stall_cycles_q    <= stall_cycles_d;
    end
  end

  assign max_outstanding = max_outstanding_q;
  assign stall_cycles    = stall_cycles_q;

  final begin
    $display("ase_tid_scheduler stats: max_outstanding=%0d stall_cycles=%0d",
             max_outstanding_q, stall_cycles_q);
  end
`endif

endmodule
